// File: rtl/clap_pattern_counter.sv
// Clap tally with refractory echo rejection and single/double classification.
// Timers advance on tick_i strobes; counters saturate or wrap by parameter.
module clap_pattern_counter #(
  parameter int CNT_W      = 32,
  parameter int TIMER_W    = 16,
  parameter int REFRACT    = 1000,
  parameter int DOUBLE_WIN = 20000,
  parameter bit SATURATE   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic             pulse_i,
  output logic [CNT_W-1:0] clap_cnt_o,
  output logic [CNT_W-1:0] single_cnt_o,
  output logic [CNT_W-1:0] double_cnt_o,
  output logic             single_o,
  output logic             double_o,
  output logic             busy_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    REF1,
    WAIT2,
    REF2
  } state_t;

  localparam logic [TIMER_W-1:0] REF_LAST = TIMER_W'(REFRACT - 1);
  localparam logic [TIMER_W-1:0] WIN_LAST = TIMER_W'(DOUBLE_WIN - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   clap_q, clap_d;
  logic [CNT_W-1:0]   single_q, single_d;
  logic [CNT_W-1:0]   double_q, double_d;
  logic               sgl_q, sgl_d;
  logic               dbl_q, dbl_d;
  logic               ovf_q, ovf_d;

  logic               inc_clap, inc_single, inc_double;
  logic [CNT_W:0]     clap_b, single_b, double_b;

  // {overflow, next value}: all-ones either holds or wraps
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = v + CNT_W'(1);
    if (&v) n = SATURATE ? v : '0;
    return {&v, n};
  endfunction

  assign clap_b   = bump(clap_q);
  assign single_b = bump(single_q);
  assign double_b = bump(double_q);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    clap_d     = clap_q;
    single_d   = single_q;
    double_d   = double_q;
    sgl_d      = 1'b0;
    dbl_d      = 1'b0;
    ovf_d      = ovf_q;
    inc_clap   = 1'b0;
    inc_single = 1'b0;
    inc_double = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pulse_i) begin
          inc_clap = 1'b1;
          timer_d  = '0;
          state_d  = REF1;
        end
      end
      REF1, REF2: begin
        if (tick_i) begin
          if (timer_q == REF_LAST) begin
            timer_d = '0;
            state_d = (state_q == REF1) ? WAIT2 : IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      WAIT2: begin
        // a pulse on the timeout cycle still counts as a double
        if (pulse_i) begin
          inc_clap   = 1'b1;
          inc_double = 1'b1;
          dbl_d      = 1'b1;
          timer_d    = '0;
          state_d    = REF2;
        end else if (tick_i) begin
          if (timer_q == WIN_LAST) begin
            inc_single = 1'b1;
            sgl_d      = 1'b1;
            timer_d    = '0;
            state_d    = IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (inc_clap) begin
      clap_d = clap_b[CNT_W-1:0];
      ovf_d  = ovf_d | clap_b[CNT_W];
    end
    if (inc_single) begin
      single_d = single_b[CNT_W-1:0];
      ovf_d    = ovf_d | single_b[CNT_W];
    end
    if (inc_double) begin
      double_d = double_b[CNT_W-1:0];
      ovf_d    = ovf_d | double_b[CNT_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      clap_q   <= '0;
      single_q <= '0;
      double_q <= '0;
      sgl_q    <= 1'b0;
      dbl_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      clap_q   <= clap_d;
      single_q <= single_d;
      double_q <= double_d;
      sgl_q    <= sgl_d;
      dbl_q    <= dbl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign clap_cnt_o   = clap_q;
  assign single_cnt_o = single_q;
  assign double_cnt_o = double_q;
  assign single_o     = sgl_q;
  assign double_o     = dbl_q;
  assign busy_o       = (state_q != IDLE);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_clap_pattern_counter.sv
// Scoreboard bench for clap_pattern_counter: saturating and wrapping
// instances share stimulus and are checked against an elapsed-tick model.
module tb_clap_pattern_counter;

  localparam int CW = 4;
  localparam int TW = 8;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int LIM = 1 << CW;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic clr_i = 1'b0;
  logic tick_i = 1'b0;
  logic pulse_i = 1'b0;

  logic [CW-1:0] s_clap, s_single, s_double;
  logic          s_so, s_do, s_busy, s_ovf;
  logic [CW-1:0] w_clap, w_single, w_double;
  logic          w_so, w_do, w_busy, w_ovf;

  always #5 clk = ~clk;

  clap_pattern_counter #(
    .CNT_W(CW), .TIMER_W(TW), .REFRACT(R),
    .DOUBLE_WIN(W), .SATURATE(1'b1)
  ) u_sat (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .tick_i(tick_i), .pulse_i(pulse_i),
    .clap_cnt_o(s_clap), .single_cnt_o(s_single),
    .double_cnt_o(s_double), .single_o(s_so),
    .double_o(s_do), .busy_o(s_busy), .ovf_o(s_ovf)
  );

  clap_pattern_counter #(
    .CNT_W(CW), .TIMER_W(TW), .REFRACT(R),
    .DOUBLE_WIN(W), .SATURATE(1'b0)
  ) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .tick_i(tick_i), .pulse_i(pulse_i),
    .clap_cnt_o(w_clap), .single_cnt_o(w_single),
    .double_cnt_o(w_double), .single_o(w_so),
    .double_o(w_do), .busy_o(w_busy), .ovf_o(w_ovf)
  );

  typedef struct {
    int sc, ss, sd;
    int wc, ws, wd;
    int so, dob, busy, ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // model: raw clap counts since clear, and ticks since last accepted clap
  int m_clap, m_single, m_double;
  int m_phase;
  int m_t;

  function automatic void chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, want);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sat.clap", int'(s_clap), e.sc);
      chk("sat.single", int'(s_single), e.ss);
      chk("sat.double", int'(s_double), e.sd);
      chk("sat.single_o", int'(s_so), e.so);
      chk("sat.double_o", int'(s_do), e.dob);
      chk("sat.busy", int'(s_busy), e.busy);
      chk("sat.ovf", int'(s_ovf), e.ovf);
      chk("wrap.clap", int'(w_clap), e.wc);
      chk("wrap.single", int'(w_single), e.ws);
      chk("wrap.double", int'(w_double), e.wd);
      chk("wrap.single_o", int'(w_so), e.so);
      chk("wrap.double_o", int'(w_do), e.dob);
      chk("wrap.busy", int'(w_busy), e.busy);
      chk("wrap.ovf", int'(w_ovf), e.ovf);
    end
  end

  function automatic int sat(int n);
    return (n >= LIM) ? LIM - 1 : n;
  endfunction

  // phase 0: idle, 1: after first clap, 2: after double clap
  task automatic model(input logic r, input logic c,
                       input logic p, input logic t);
    exp_t e;
    int se, de;
    se = 0;
    de = 0;
    if (r || c) begin
      m_clap = 0;
      m_single = 0;
      m_double = 0;
      m_phase = 0;
      m_t = 0;
    end else if (m_phase == 0) begin
      if (p) begin
        m_clap++;
        m_phase = 1;
        m_t = 0;
      end
    end else if (m_phase == 1) begin
      if (m_t < R) begin
        if (t) m_t++;
      end else if (p) begin
        m_clap++;
        m_double++;
        de = 1;
        m_phase = 2;
        m_t = 0;
      end else if (t) begin
        if (m_t == R + W - 1) begin
          m_single++;
          se = 1;
          m_phase = 0;
        end else begin
          m_t++;
        end
      end
    end else begin
      if (t) begin
        m_t++;
        if (m_t == R) m_phase = 0;
      end
    end
    e.sc = sat(m_clap);
    e.ss = sat(m_single);
    e.sd = sat(m_double);
    e.wc = m_clap % LIM;
    e.ws = m_single % LIM;
    e.wd = m_double % LIM;
    e.so = se;
    e.dob = de;
    e.busy = (m_phase != 0) ? 1 : 0;
    e.ovf = (m_clap >= LIM || m_single >= LIM ||
             m_double >= LIM) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic c,
                      input logic p, input logic t);
    @(negedge clk);
    #1;
    rst_i = r;
    clr_i = c;
    pulse_i = p;
    tick_i = t;
    model(r, c, p, t);
    @(posedge clk);
  endtask

  task automatic run(input int n, input logic p, input logic t);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, p, t);
  endtask

  task automatic clap();
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    m_clap = 0;
    m_single = 0;
    m_double = 0;
    m_phase = 0;
    m_t = 0;

    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // single
    run(9, 1'b0, 1'b1);
    clap();
    run(20, 1'b0, 1'b1);
    // double
    clap();
    run(6, 1'b0, 1'b1);
    clap();
    run(10, 1'b0, 1'b1);
    // refractory rejection
    clap();
    clap();
    run(1, 1'b0, 1'b1);
    clap();
    run(20, 1'b0, 1'b1);
    // pulse on the timeout cycle
    clap();
    run(11, 1'b0, 1'b1);
    clap();
    run(10, 1'b0, 1'b1);
    // clear with pulse while waiting for second clap
    clap();
    run(6, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1);
    clap();
    run(20, 1'b0, 1'b1);
    // frozen timebase, pulses during refractory ignored
    clap();
    run(2, 1'b0, 1'b1);
    run(4, 1'b0, 1'b0);
    run(3, 1'b1, 1'b0);
    run(20, 1'b0, 1'b1);
    // saturation / wrap from a clean start
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      clap();
      run(15, 1'b0, 1'b1);
    end
    clap();
    run(6, 1'b0, 1'b1);
    clap();
    run(8, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 999) == 0),
           ($urandom_range(0, 399) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #2;
    chk("scoreboard.drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
